// File: rtl/kmul_pipe.sv
// Two-stage 12x12 unsigned multiplier with valid/ready flow control and a sideband tag.
// Optional sticky operand range check is enabled by defining KMUL_RANGE_CHK_EN.
module kmul_pipe #(
  parameter int WIDA = 12,
  parameter int WIDC = 24,
  parameter int TAGW = 8,
  parameter int QMOD = 3329
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WIDA-1:0] a,
  input  logic [WIDA-1:0] b,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WIDC-1:0] c,
  output logic [TAGW-1:0] out_tag,
  output logic            busy,
  output logic            err
);

  logic            vld_p1, vld_p2;
  logic [WIDA-1:0] a_p1, b_p1;
  logic [TAGW-1:0] tag_p1, tag_p2;
  logic [WIDC-1:0] c_p2;
  logic            s1_load, s2_load, in_xfer;

  function automatic logic [WIDC-1:0] mul_full(input logic [WIDA-1:0] x,
                                               input logic [WIDA-1:0] y);
    return WIDC'(x) * WIDC'(y);
  endfunction

  // S2 frees up when empty or draining; S1 can then always advance into it.
  assign s2_load  = !vld_p2 || out_ready;
  assign s1_load  = !vld_p1 || s2_load;
  assign in_ready = s1_load;
  assign in_xfer  = in_valid && s1_load;

  // Stage 1: operand and tag capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1 <= 1'b0;
      a_p1   <= '0;
      b_p1   <= '0;
      tag_p1 <= '0;
    end else begin
      if (s1_load) vld_p1 <= in_valid;
      if (in_xfer) begin
        a_p1   <= a;
        b_p1   <= b;
        tag_p1 <= in_tag;
      end
    end
  end

  // Stage 2: full-width product and tag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p2 <= 1'b0;
      c_p2   <= '0;
      tag_p2 <= '0;
    end else begin
      if (s2_load) vld_p2 <= vld_p1;
      if (s2_load && vld_p1) begin
        c_p2   <= mul_full(a_p1, b_p1);
        tag_p2 <= tag_p1;
      end
    end
  end

  assign out_valid = vld_p2;
  assign c         = c_p2;
  assign out_tag   = tag_p2;
  assign busy      = vld_p1 | vld_p2;

`ifdef KMUL_RANGE_CHK_EN
  localparam logic [WIDA-1:0] QLIM = WIDA'(QMOD);
  logic err_flag;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_flag <= 1'b0;
    end else if (in_xfer && ((a >= QLIM) || (b >= QLIM))) begin
      err_flag <= 1'b1;
    end
  end

  assign err = err_flag;
`else
  logic unused_qmod;
  assign unused_qmod = ^QMOD;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_kmul_pipe.sv
// Scoreboard bench for kmul_pipe: reset, latency, streaming, backpressure, mid-stream reset, range flag.
module tb_kmul_pipe;
  localparam int WIDA = 12;
  localparam int WIDC = 24;
  localparam int TAGW = 8;
`ifdef KMUL_RANGE_CHK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b1;
  logic [WIDA-1:0] a = '0;
  logic [WIDA-1:0] b = '0;
  logic [TAGW-1:0] in_tag = '0;
  logic            in_ready, out_valid, busy, err;
  logic [WIDC-1:0] c;
  logic [TAGW-1:0] out_tag;

  typedef struct packed {
    logic [WIDC-1:0] c;
    logic [TAGW-1:0] tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  kmul_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .out_tag(out_tag), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WIDA-1:0] x, input logic [WIDA-1:0] y,
                       input logic [TAGW-1:0] t);
    in_valid = v;
    a        = x;
    b        = y;
    in_tag   = t;
  endtask

  // Pop before push so a same-cycle accept never matches its own output.
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          mon_e = sb.pop_front();
          check("sb_c", 32'(c), 32'(mon_e.c));
          check("sb_tag", 32'(out_tag), 32'(mon_e.tag));
        end
      end
      if (in_valid && in_ready) begin
        mon_e.c   = WIDC'(a) * WIDC'(b);
        mon_e.tag = in_tag;
        sb.push_back(mon_e);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_c", 32'(c), 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b1;
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // single op, latency 2
    drive(1'b1, 12'd3328, 12'd3328, 8'h5A);
    check("single_ready", 32'(in_ready), 32'd1);
    tick();
    drive(1'b0, 12'd0, 12'd0, 8'h00);
    check("single_lat1_valid", 32'(out_valid), 32'd0);
    check("single_lat1_busy", 32'(busy), 32'd1);
    tick();
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_c", 32'(c), 32'h00A90000);
    check("single_tag", 32'(out_tag), 32'h5A);
    tick();
    check("single_busy_after", 32'(busy), 32'd0);
    check("single_valid_after", 32'(out_valid), 32'd0);

    // streaming at full rate
    for (int i = 1; i <= 17; i++) begin
      if (i < 17) drive(1'b1, 12'(i), 12'd1, 8'(i));
      else        drive(1'b1, 12'd4095, 12'd4095, 8'h11);
      check("stream_ready", 32'(in_ready), 32'd1);
      tick();
    end
    drive(1'b0, 12'd0, 12'd0, 8'h00);
    tick();
    check("stream_max_c", 32'(c), 32'h00FFE001);
    check("stream_max_tag", 32'(out_tag), 32'h11);
    tick();
    check("stream_drained", 32'(sb.size()), 32'd0);
    check("stream_idle", 32'(out_valid), 32'd0);

    // backpressure for 5 cycles, then simultaneous accept/shift/output
    out_ready = 1'b0;
    drive(1'b1, 12'd10, 12'd11, 8'd1);
    check("bp_ready0", 32'(in_ready), 32'd1);
    tick();
    drive(1'b1, 12'd20, 12'd21, 8'd2);
    check("bp_ready1", 32'(in_ready), 32'd1);
    tick();
    drive(1'b1, 12'd30, 12'd31, 8'd3);
    repeat (3) begin
      check("bp_ready_low", 32'(in_ready), 32'd0);
      check("bp_tag_hold", 32'(out_tag), 32'd1);
      check("bp_c_hold", 32'(c), 32'd110);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("simul_ready", 32'(in_ready), 32'd1);
    check("simul_tag1", 32'(out_tag), 32'd1);
    tick();
    drive(1'b0, 12'd0, 12'd0, 8'h00);
    check("simul_valid", 32'(out_valid), 32'd1);
    check("simul_tag2", 32'(out_tag), 32'd2);
    check("simul_busy", 32'(busy), 32'd1);
    tick();
    check("simul_tag3", 32'(out_tag), 32'd3);
    check("simul_c3", 32'(c), 32'd930);
    tick();
    check("bp_idle", 32'(out_valid), 32'd0);
    check("bp_drained", 32'(sb.size()), 32'd0);

    // reset with two ops in flight
    drive(1'b1, 12'd5, 12'd6, 8'h21);
    tick();
    drive(1'b1, 12'd7, 12'd8, 8'h22);
    tick();
    drive(1'b0, 12'd0, 12'd0, 8'h00);
    out_ready = 1'b0;
    #1;
    check("mid_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_c", 32'(c), 32'd0);
    check("mid_rst_tag", 32'(out_tag), 32'd0);
    sb.delete();
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 12'd2, 12'd3, 8'h33);
    tick();
    drive(1'b0, 12'd0, 12'd0, 8'h00);
    check("post_rst_lat1", 32'(out_valid), 32'd0);
    tick();
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_c", 32'(c), 32'd6);
    check("post_rst_tag", 32'(out_tag), 32'h33);
    tick();

    // range flag
    drive(1'b1, 12'd3328, 12'd3328, 8'h41);
    tick();
    drive(1'b1, 12'd3329, 12'd1, 8'h42);
    check("range_in_ok", 32'(err), 32'd0);
    tick();
    drive(1'b0, 12'd0, 12'd0, 8'h00);
    check("range_err", 32'(err), 32'(EXP_ERR));
    tick();
    check("range_c", 32'(c), 32'd3329);
    check("range_tag", 32'(out_tag), 32'h42);
    tick();
    repeat (2) tick();
    check("range_err_sticky", 32'(err), 32'(EXP_ERR));
    check("final_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
